// File: rtl/jbi_credit_aok_gen.sv
// Credit pool tracker that drives set/clr pulses for a downstream AOK flop.
// Optional stall statistics counter enabled by defining JBI_CREDIT_AOK_STATS_EN.
// The credit-return input is named rel because "release" is a reserved word.
module jbi_credit_aok_gen #(
  parameter int STATS_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               consume,
  input  logic               rel,
  input  logic [4:0]         cfg_max,
  input  logic [4:0]         cfg_hyst,
  input  logic               err_clr,
  output logic               aok_set,
  output logic               aok_clr,
  output logic [4:0]         credit_cnt,
  output logic               udf_err,
  output logic               ovf_err,
  output logic [STATS_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_OK    = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  state_t     state_reg;
  logic [4:0] emax_reg;
  logic [4:0] cnt_reg;
  logic       aok_set_reg;
  logic       aok_clr_reg;
  logic       udf_reg;
  logic       ovf_reg;

  logic [4:0] emax_cfg;
  logic [4:0] ehyst;
  logic [4:0] cnt_next;
  logic       udf_evt;
  logic       ovf_evt;

  // Pool size is clamped to 1..16; it is only captured while in INIT.
  always_comb begin
    emax_cfg = cfg_max;
    if (cfg_max == 5'd0)
      emax_cfg = 5'd1;
    else if (cfg_max > 5'd16)
      emax_cfg = 5'd16;
  end

  // Re-open threshold is clamped to 1..EMAX against the captured pool size.
  always_comb begin
    ehyst = cfg_hyst;
    if (cfg_hyst == 5'd0)
      ehyst = 5'd1;
    else if (cfg_hyst > emax_reg)
      ehyst = emax_reg;
  end

  always_comb begin
    cnt_next = cnt_reg;
    udf_evt  = 1'b0;
    ovf_evt  = 1'b0;
    if (state_reg != ST_INIT) begin
      if (consume && !rel) begin
        if (cnt_reg == 5'd0)
          udf_evt = 1'b1;
        else
          cnt_next = cnt_reg - 5'd1;
      end else if (rel && !consume) begin
        if (cnt_reg == emax_reg)
          ovf_evt = 1'b1;
        else
          cnt_next = cnt_reg + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_INIT;
      emax_reg    <= 5'd1;
      cnt_reg     <= 5'd0;
      aok_set_reg <= 1'b0;
      aok_clr_reg <= 1'b0;
      udf_reg     <= 1'b0;
      ovf_reg     <= 1'b0;
    end else begin
      aok_set_reg <= 1'b0;
      aok_clr_reg <= 1'b0;
      case (state_reg)
        ST_INIT: begin
          emax_reg    <= emax_cfg;
          cnt_reg     <= emax_cfg;
          state_reg   <= ST_OK;
          aok_set_reg <= 1'b1;
        end
        ST_OK: begin
          cnt_reg <= cnt_next;
          if (cnt_next == 5'd0) begin
            state_reg   <= ST_STALL;
            aok_clr_reg <= 1'b1;
          end
        end
        ST_STALL: begin
          cnt_reg <= cnt_next;
          if (cnt_next >= ehyst) begin
            state_reg   <= ST_OK;
            aok_set_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= ST_INIT;
        end
      endcase
      // A new error event takes priority over a simultaneous clear.
      if (udf_evt)
        udf_reg <= 1'b1;
      else if (err_clr)
        udf_reg <= 1'b0;
      if (ovf_evt)
        ovf_reg <= 1'b1;
      else if (err_clr)
        ovf_reg <= 1'b0;
    end
  end

  assign aok_set    = aok_set_reg;
  assign aok_clr    = aok_clr_reg;
  assign credit_cnt = cnt_reg;
  assign udf_err    = udf_reg;
  assign ovf_err    = ovf_reg;

`ifdef JBI_CREDIT_AOK_STATS_EN
  logic [STATS_W-1:0] stall_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt_reg <= '0;
    else if (err_clr)
      stall_cnt_reg <= '0;
    else if (state_reg == ST_STALL && stall_cnt_reg != {STATS_W{1'b1}})
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
  end

  assign stall_cycles = stall_cnt_reg;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_jbi_credit_aok_gen.sv
// Directed bench for jbi_credit_aok_gen; stall statistics expectations follow
// JBI_CREDIT_AOK_STATS_EN.
module tb_jbi_credit_aok_gen;

  localparam int STATS_W = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               consume;
  logic               rel;
  logic [4:0]         cfg_max;
  logic [4:0]         cfg_hyst;
  logic               err_clr;
  logic               aok_set;
  logic               aok_clr;
  logic [4:0]         credit_cnt;
  logic               udf_err;
  logic               ovf_err;
  logic [STATS_W-1:0] stall_cycles;

  int checks   = 0;
  int failures = 0;

  jbi_credit_aok_gen #(.STATS_W(STATS_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .consume      (consume),
    .rel          (rel),
    .cfg_max      (cfg_max),
    .cfg_hyst     (cfg_hyst),
    .err_clr      (err_clr),
    .aok_set      (aok_set),
    .aok_clr      (aok_clr),
    .credit_cnt   (credit_cnt),
    .udf_err      (udf_err),
    .ovf_err      (ovf_err),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

`ifdef JBI_CREDIT_AOK_STATS_EN
  localparam int STALL10_EXP = 10;
`else
  localparam int STALL10_EXP = 0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cnt"}, 32'(credit_cnt), 0);
    chk({tag, "_set"}, 32'(aok_set), 0);
    chk({tag, "_clr"}, 32'(aok_clr), 0);
    chk({tag, "_udf"}, 32'(udf_err), 0);
    chk({tag, "_ovf"}, 32'(ovf_err), 0);
    chk({tag, "_stall"}, 32'(stall_cycles), 0);
  endtask

  task automatic do_reset(input logic [4:0] mx, input logic [4:0] hy);
    rst = 1'b1;
    cfg_max = mx;
    cfg_hyst = hy;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    consume = 0; rel = 0; err_clr = 0;
    // Reset state
    do_reset(5'd4, 5'd2);
    rst = 1'b1;
    tick();
    chk_all_zero("rst");

    // INIT -> OK with aok_set pulse, count = 4
    rst = 1'b0;
    tick();
    chk("init_set", 32'(aok_set), 1);
    chk("init_cnt", 32'(credit_cnt), 4);
    tick();
    chk("init_set_once", 32'(aok_set), 0);
    chk("init_cnt_hold", 32'(credit_cnt), 4);

    // Four consumes: aok_clr coincident with count reaching 0
    consume = 1;
    for (int i = 3; i >= 1; i--) begin
      tick();
      chk("dec_cnt", 32'(credit_cnt), 32'(i));
      chk("dec_noclr", 32'(aok_clr), 0);
    end
    tick();
    chk("stall_cnt", 32'(credit_cnt), 0);
    chk("stall_clr", 32'(aok_clr), 1);
    consume = 0;
    tick();
    chk("stall_clr_once", 32'(aok_clr), 0);

    // Hysteresis 2: first release no set, second release sets
    rel = 1;
    tick();
    chk("rel1_cnt", 32'(credit_cnt), 1);
    chk("rel1_noset", 32'(aok_set), 0);
    tick();
    chk("rel2_cnt", 32'(credit_cnt), 2);
    chk("rel2_set", 32'(aok_set), 1);
    rel = 0;
    tick();
    chk("rel2_set_once", 32'(aok_set), 0);

    // Back to 0 then simultaneous consume/release at 0
    consume = 1;
    tick(); tick();
    chk("stall2_cnt", 32'(credit_cnt), 0);
    chk("stall2_clr", 32'(aok_clr), 1);
    rel = 1;
    tick();
    chk("both_cnt", 32'(credit_cnt), 0);
    chk("both_udf", 32'(udf_err), 0);
    chk("both_ovf", 32'(ovf_err), 0);
    chk("both_set", 32'(aok_set), 0);
    chk("both_clr", 32'(aok_clr), 0);

    // Underflow
    rel = 0;
    tick();
    chk("udf_flag", 32'(udf_err), 1);
    chk("udf_cnt", 32'(credit_cnt), 0);
    consume = 0;

    // Fill back to EMAX then overflow
    rel = 1;
    tick(); tick(); tick(); tick();
    chk("fill_cnt", 32'(credit_cnt), 4);
    chk("fill_ovf", 32'(ovf_err), 0);
    tick();
    chk("ovf_flag", 32'(ovf_err), 1);
    chk("ovf_cnt", 32'(credit_cnt), 4);
    chk("udf_sticky", 32'(udf_err), 1);
    rel = 0;

    // Clear
    err_clr = 1;
    tick();
    chk("clr_udf", 32'(udf_err), 0);
    chk("clr_ovf", 32'(ovf_err), 0);

    // Error wins over simultaneous clear
    rel = 1;
    tick();
    chk("win_ovf", 32'(ovf_err), 1);
    rel = 0; err_clr = 0;

    // cfg_max=0 -> EMAX=1; consume during INIT ignored
    do_reset(5'd0, 5'd2);
    consume = 1;
    tick();
    chk("m0_cnt", 32'(credit_cnt), 1);
    chk("m0_set", 32'(aok_set), 1);
    chk("m0_init_udf", 32'(udf_err), 0);
    tick();
    chk("m0_stall_cnt", 32'(credit_cnt), 0);
    chk("m0_stall_clr", 32'(aok_clr), 1);
    consume = 0; rel = 1;
    tick();
    chk("m0_reopen_cnt", 32'(credit_cnt), 1);
    chk("m0_reopen_set", 32'(aok_set), 1);
    tick();
    chk("m0_ovf", 32'(ovf_err), 1);
    chk("m0_ovf_cnt", 32'(credit_cnt), 1);
    rel = 0;

    // cfg_max=20 -> EMAX=16; cfg_hyst=0 -> reopen after one release
    do_reset(5'd20, 5'd0);
    tick();
    chk("m20_cnt", 32'(credit_cnt), 16);
    consume = 1;
    for (int i = 0; i < 16; i++) tick();
    chk("m20_stall_cnt", 32'(credit_cnt), 0);
    chk("m20_stall_clr", 32'(aok_clr), 1);
    consume = 0; rel = 1;
    tick();
    chk("m20_reopen_cnt", 32'(credit_cnt), 1);
    chk("m20_reopen_set", 32'(aok_set), 1);
    rel = 0;

    // Hold STALL for 10 cycles, then async reset mid-stall
    do_reset(5'd4, 5'd2);
    tick();
    consume = 1;
    for (int i = 0; i < 4; i++) tick();
    consume = 0;
    chk("st_entry_clr", 32'(aok_clr), 1);
    for (int i = 0; i < 10; i++) tick();
    chk("st_cycles", 32'(stall_cycles), 32'(STALL10_EXP));
    chk("st_cnt", 32'(credit_cnt), 0);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    tick();
    chk_all_zero("midrst_hold");
    rst = 1'b0;
    tick();
    chk("post_rst_set", 32'(aok_set), 1);
    chk("post_rst_cnt", 32'(credit_cnt), 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
